seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_if.sv | 20 ++
 rtl/seg_scan_driver.sv | 98 +++++++++
 tb/tb_seg_scan_driver.sv | 128 ++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Time/control inputs and multiplexed 7-segment drive
// for the six-digit hh.mm.ss scanner.
interface seg_scan_if;
    logic [23:0] time_bcd;
    logic        blank;
    logic        dp_en;
    logic [6:0]  seg;
    logic        dp;
    logic [5:0]  an;

    modport master (
        output time_bcd, blank, dp_en,
        input  seg, dp, an
    );

    modport slave (
        input  time_bcd, blank, dp_en,
        output seg, dp, an
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed 7-segment scanner for an hh.mm.ss clock,
// with per-frame snapshot, anti-ghost gap and leading-zero blanking.
module seg_scan_driver #(
    parameter int SCAN_DIV       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit LZB            = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    seg_scan_if.slave bus
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(SCAN_DIV - 1);

    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [5:0] AN_OFF  = AN_ACTIVE_LOW ? 6'h3F : 6'h00;

    logic [PW-1:0] p, p_nxt;
    logic [2:0]    i, i_nxt;
    logic [23:0]   snap, snap_nxt;
    logic          fresh;
    logic          load;
    logic [3:0]    nib;
    logic [6:0]    code;
    logic          dark;
    logic [6:0]    seg_act;
    logic [5:0]    an_act;
    logic          dp_act;

    always_comb begin
        p_nxt = (p == LAST) ? '0 : p + 1'b1;
        i_nxt = i;
        if (p == LAST) i_nxt = (i == 3'd5) ? 3'd0 : i + 3'd1;
    end

    // The first edge out of reset also starts a frame.
    assign load     = fresh || (p_nxt == '0 && i_nxt == 3'd0);
    assign snap_nxt = load ? bus.time_bcd : snap;

    always_comb begin
        nib = 4'h0;
        unique case (i_nxt)
            3'd0: nib = snap_nxt[3:0];
            3'd1: nib = snap_nxt[7:4];
            3'd2: nib = snap_nxt[11:8];
            3'd3: nib = snap_nxt[15:12];
            3'd4: nib = snap_nxt[19:16];
            3'd5: nib = snap_nxt[23:20];
            default: nib = 4'h0;
        endcase
    end

    always_comb begin
        unique case (nib)
            4'd0: code = 7'h3F;
            4'd1: code = 7'h06;
            4'd2: code = 7'h5B;
            4'd3: code = 7'h4F;
            4'd4: code = 7'h66;
            4'd5: code = 7'h6D;
            4'd6: code = 7'h7D;
            4'd7: code = 7'h07;
            4'd8: code = 7'h7F;
            4'd9: code = 7'h6F;
            default: code = 7'h40;
        endcase
    end

    assign dark = (p_nxt == LAST) || bus.blank ||
                  (LZB && i_nxt == 3'd5 && snap_nxt[23:20] == 4'h0);

    assign seg_act = dark ? 7'h00 : code;
    assign an_act  = dark ? 6'h00 : (6'd1 << i_nxt);
    assign dp_act  = !dark && bus.dp_en &&
                     (i_nxt == 3'd2 || i_nxt == 3'd4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p      <= '0;
            i      <= 3'd0;
            snap   <= 24'h0;
            fresh  <= 1'b1;
            bus.seg <= SEG_OFF;
            bus.dp  <= DP_OFF;
            bus.an  <= AN_OFF;
        end else begin
            p      <= p_nxt;
            i      <= i_nxt;
            snap   <= snap_nxt;
            fresh  <= 1'b0;
            bus.seg <= SEG_ACTIVE_LOW ? ~seg_act : seg_act;
            bus.dp  <= SEG_ACTIVE_LOW ? ~dp_act : dp_act;
            bus.an  <= AN_ACTIVE_LOW ? ~an_act : an_act;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized and directed bench for seg_scan_driver against
// a frame-position reference model.
module tb_seg_scan_driver;
    localparam int DIV   = 4;
    localparam int FRAME = DIV * 6;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   n = 0;
    logic [23:0] msnap = 24'h0;
    logic [6:0]  font [16];

    seg_scan_if bus ();

    seg_scan_driver #(.SCAN_DIV(DIV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s n=%0d got=%h exp=%h", tag, n, got, exp);
        end
    endtask

    // Expected {an,seg,dp} after edge number k since reset release.
    function automatic logic [13:0] expect_out(input int k);
        int p, d;
        logic dk, dpl;
        logic [3:0] nb;
        p  = k % DIV;
        d  = (k / DIV) % 6;
        nb = msnap[d*4 +: 4];
        dk = (p == DIV - 1) || bus.blank ||
             (d == 5 && msnap[23:20] == 4'h0);
        dpl = !dk && bus.dp_en && (d == 2 || d == 4);
        if (dk) return {6'h3F, 7'h7F, 1'b1};
        return {~(6'd1 << d), ~font[nb], ~dpl};
    endfunction

    task automatic cycle();
        logic [13:0] e;
        @(posedge clk);
        n++;
        if (n == 1 || n % FRAME == 0) msnap = bus.time_bcd;
        e = expect_out(n);
        #1;
        check("out", {18'h0, bus.an, bus.seg, bus.dp}, {18'h0, e});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst", {18'h0, bus.an, bus.seg, bus.dp},
              {18'h0, 6'h3F, 7'h7F, 1'b1});
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold", {18'h0, bus.an, bus.seg, bus.dp},
              {18'h0, 6'h3F, 7'h7F, 1'b1});
        rst = 1'b0;
        n = 0;
    endtask

    function automatic logic [23:0] rand_time();
        logic [23:0] t;
        for (int k = 0; k < 6; k++)
            t[k*4 +: 4] = ($urandom_range(0, 3) == 0) ?
                          4'($urandom_range(0, 15)) :
                          4'($urandom_range(0, 9));
        return t;
    endfunction

    initial begin
        font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D,
                 7'h07, 7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40,
                 7'h40, 7'h40};
        bus.time_bcd = 24'h123456;
        bus.blank    = 1'b0;
        bus.dp_en    = 1'b0;
        #1;
        do_reset();
        cycle();
        check("slot0_first", {18'h0, bus.an, bus.seg, bus.dp},
              {18'h0, 6'h3E, 7'h02, 1'b1});
        repeat (23) cycle();

        bus.time_bcd = 24'h095959;
        do_reset();
        repeat (24) cycle();

        bus.time_bcd = 24'h235959;
        do_reset();
        repeat (9) cycle();
        bus.time_bcd = 24'h000000;
        repeat (39) cycle();

        bus.time_bcd = 24'h00000A;
        bus.dp_en    = 1'b1;
        do_reset();
        repeat (48) cycle();

        bus.dp_en = 1'b0;
        repeat (5) cycle();
        bus.blank = 1'b1;
        repeat (24) cycle();
        bus.blank = 1'b0;
        repeat (10) cycle();

        for (int r = 0; r < 800; r++) begin
            if ($urandom_range(0, 29) == 0) bus.time_bcd = rand_time();
            if ($urandom_range(0, 19) == 0) bus.blank = ~bus.blank;
            if ($urandom_range(0, 15) == 0) bus.dp_en = ~bus.dp_en;
            if ($urandom_range(0, 149) == 0) do_reset();
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
